// File: rtl/calendar_date_pkg.sv
// Shared types, month tables and leap/month-length helpers for the calendar date counter.
package calendar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    CHECK
  } cal_state_t;

  localparam logic [3:0] FEB = 4'd2;
  localparam logic [3:0] DEC = 4'd12;

  localparam logic [4:0] MONTH_DAYS [12] = '{
    5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
    5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
  };

  localparam logic [2:0] MONDAY    = 3'd0;
  localparam logic [2:0] TUESDAY   = 3'd1;
  localparam logic [2:0] WEDNESDAY = 3'd2;
  localparam logic [2:0] THURSDAY  = 3'd3;
  localparam logic [2:0] FRIDAY    = 3'd4;
  localparam logic [2:0] SATURDAY  = 3'd5;
  localparam logic [2:0] SUNDAY    = 3'd6;

  localparam logic [8:0] MOD400_LAST = 9'd399;

  // Returns 0 for an out-of-range month so callers can treat it as "no legal day".
  function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
    logic [4:0] d;
    d = 5'd0;
    if (month >= 4'd1 && month <= DEC) begin
      if (month == FEB && leap) d = 5'd29;
      else                      d = MONTH_DAYS[month - 4'd1];
    end
    return d;
  endfunction

  // Bit 1:0 of the year equals bit 1:0 of year mod 400 because 400 is a multiple of 4.
  function automatic logic is_leap(input logic [1:0] year_lo, input logic [8:0] mod400);
    return (year_lo == 2'd0) && (mod400 != 9'd100) && (mod400 != 9'd200) && (mod400 != 9'd300);
  endfunction

endpackage

// File: rtl/calendar_date_if.sv
// Ready/valid date-load port of the calendar counter, with its done/error completion pulses.
interface calendar_date_if #(parameter int YEAR_W = 12);
  logic              set_valid;
  logic              set_ready;
  logic [4:0]        set_day;
  logic [3:0]        set_month;
  logic [YEAR_W-1:0] set_year;
  logic [2:0]        set_weekday;
  logic              set_done;
  logic              set_err;

  modport master (
    output set_valid, set_day, set_month, set_year, set_weekday,
    input  set_ready, set_done, set_err
  );

  modport slave (
    input  set_valid, set_day, set_month, set_year, set_weekday,
    output set_ready, set_done, set_err
  );
endinterface

// File: rtl/calendar_date_leap_year_tracker.sv
// Holds year mod 400 incrementally (no divider) and derives the Gregorian leap flag from it.
module leap_year_tracker
  import calendar_pkg::*;
#(
  parameter logic [8:0] RESET_VAL = 9'd0
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic       inc,
  input  logic       wrap,
  input  logic       load,
  input  logic [8:0] load_val,
  input  logic [1:0] year_lo,
  output logic [8:0] mod400,
  output logic       leap
);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)    mod400 <= RESET_VAL;
    else if (load)   mod400 <= load_val;
    else if (wrap)   mod400 <= 9'd0;
    else if (inc)    mod400 <= (mod400 == MOD400_LAST) ? 9'd0 : mod400 + 9'd1;
  end

  assign leap = is_leap(year_lo, mod400);

endmodule

// File: rtl/calendar_date.sv
// Day/month/year counter advanced by day_tick, with a validated ready/valid date load.
// Optional weekday counter is built when CAL_WEEKDAY_EN is defined.
module calendar_date
  import calendar_pkg::*;
#(
  parameter int YEAR_W        = 12,
  parameter int YEAR_RESET    = 2000,
  parameter int WEEKDAY_RESET = 5
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              day_tick,
  calendar_date_if.slave    set_if,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic [2:0]        weekday,
  output logic              month_wrap,
  output logic              year_wrap
);

  localparam logic [YEAR_W-1:0] YEAR_MAX     = '1;
  localparam logic [YEAR_W-1:0] YEAR_INIT    = YEAR_W'(YEAR_RESET);
  localparam logic [YEAR_W-1:0] FOUR_HUNDRED = YEAR_W'(400);
  localparam logic [8:0]        MOD400_INIT  = 9'(YEAR_RESET % 400);

  cal_state_t        state_q, state_n;
  logic [4:0]        day_q, day_n, cap_day_q, cap_day_n;
  logic [3:0]        month_q, month_n, cap_month_q, cap_month_n;
  logic [YEAR_W-1:0] year_q, year_n, cap_year_q, cap_year_n, rem_q, rem_n, rem_sub;
  logic              pending_q, pending_n;
  logic              done_q, done_n, err_q, err_n, mw_q, mw_n, yw_q, yw_n;
  logic              trk_inc, trk_wrap, trk_load;
  logic [8:0]        mod400;
  logic              leap, check_bad;
  logic [4:0]        adv_day;
  logic [3:0]        adv_month;
  logic [YEAR_W-1:0] adv_year;
  logic              adv_mw, adv_yw, adv_inc, adv_wrap;
`ifdef CAL_WEEKDAY_EN
  logic [2:0]        wd_q, wd_n, cap_wd_q, cap_wd_n;
`endif

  leap_year_tracker #(.RESET_VAL(MOD400_INIT)) u_leap (
    .clock    (clock),
    .clear_n  (clear_n),
    .inc      (trk_inc),
    .wrap     (trk_wrap),
    .load     (trk_load),
    .load_val (rem_q[8:0]),
    .year_lo  (year_q[1:0]),
    .mod400   (mod400),
    .leap     (leap)
  );

  // The date one tick ahead of the current one; applied only when a tick is taken.
  always_comb begin
    adv_day   = day_q + 5'd1;
    adv_month = month_q;
    adv_year  = year_q;
    adv_mw    = 1'b0;
    adv_yw    = 1'b0;
    adv_inc   = 1'b0;
    adv_wrap  = 1'b0;
    if (day_q >= days_in_month(month_q, leap)) begin
      adv_day = 5'd1;
      adv_mw  = 1'b1;
      if (month_q == DEC) begin
        adv_month = 4'd1;
        adv_yw    = 1'b1;
        if (year_q == YEAR_MAX) begin
          adv_year = '0;
          adv_wrap = 1'b1;
        end else begin
          adv_year = year_q + 1'b1;
          adv_inc  = 1'b1;
        end
      end else begin
        adv_month = month_q + 4'd1;
      end
    end
  end

  // In CHECK the remainder is < 400, so its low bits stand in for year mod 400.
  assign rem_sub   = rem_q - FOUR_HUNDRED;
  assign check_bad = (cap_month_q == 4'd0) || (cap_month_q > DEC) || (cap_day_q == 5'd0) ||
                     (cap_day_q > days_in_month(cap_month_q, is_leap(rem_q[1:0], rem_q[8:0])))
`ifdef CAL_WEEKDAY_EN
                     || (cap_wd_q > SUNDAY)
`endif
                     ;

  always_comb begin
    state_n     = state_q;
    day_n       = day_q;
    month_n     = month_q;
    year_n      = year_q;
    cap_day_n   = cap_day_q;
    cap_month_n = cap_month_q;
    cap_year_n  = cap_year_q;
    rem_n       = rem_q;
    pending_n   = pending_q;
    done_n      = 1'b0;
    err_n       = 1'b0;
    mw_n        = 1'b0;
    yw_n        = 1'b0;
    trk_inc     = 1'b0;
    trk_wrap    = 1'b0;
    trk_load    = 1'b0;
`ifdef CAL_WEEKDAY_EN
    wd_n        = wd_q;
    cap_wd_n    = cap_wd_q;
`endif
    case (state_q)
      IDLE: begin
        if (pending_q || (!set_if.set_valid && day_tick)) begin
          day_n     = adv_day;
          month_n   = adv_month;
          year_n    = adv_year;
          mw_n      = adv_mw;
          yw_n      = adv_yw;
          trk_inc   = adv_inc;
          trk_wrap  = adv_wrap;
          pending_n = pending_q & day_tick;
`ifdef CAL_WEEKDAY_EN
          wd_n      = (wd_q == SUNDAY) ? MONDAY : wd_q + 3'd1;
`endif
        end else if (set_if.set_valid) begin
          cap_day_n   = set_if.set_day;
          cap_month_n = set_if.set_month;
          cap_year_n  = set_if.set_year;
          rem_n       = set_if.set_year;
          pending_n   = day_tick;
          state_n     = (set_if.set_year >= FOUR_HUNDRED) ? CALC : CHECK;
`ifdef CAL_WEEKDAY_EN
          cap_wd_n    = set_if.set_weekday;
`endif
        end
      end
      CALC: begin
        rem_n = rem_sub;
        if (rem_sub < FOUR_HUNDRED) state_n = CHECK;
        if (day_tick) pending_n = 1'b1;
      end
      CHECK: begin
        done_n  = 1'b1;
        err_n   = check_bad;
        state_n = IDLE;
        if (day_tick) pending_n = 1'b1;
        if (!check_bad) begin
          day_n    = cap_day_q;
          month_n  = cap_month_q;
          year_n   = cap_year_q;
          trk_load = 1'b1;
`ifdef CAL_WEEKDAY_EN
          wd_n     = cap_wd_q;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= IDLE;
      day_q       <= 5'd1;
      month_q     <= 4'd1;
      year_q      <= YEAR_INIT;
      cap_day_q   <= 5'd1;
      cap_month_q <= 4'd1;
      cap_year_q  <= YEAR_INIT;
      rem_q       <= '0;
      pending_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mw_q        <= 1'b0;
      yw_q        <= 1'b0;
`ifdef CAL_WEEKDAY_EN
      wd_q        <= 3'(WEEKDAY_RESET);
      cap_wd_q    <= 3'd0;
`endif
    end else begin
      state_q     <= state_n;
      day_q       <= day_n;
      month_q     <= month_n;
      year_q      <= year_n;
      cap_day_q   <= cap_day_n;
      cap_month_q <= cap_month_n;
      cap_year_q  <= cap_year_n;
      rem_q       <= rem_n;
      pending_q   <= pending_n;
      done_q      <= done_n;
      err_q       <= err_n;
      mw_q        <= mw_n;
      yw_q        <= yw_n;
`ifdef CAL_WEEKDAY_EN
      wd_q        <= wd_n;
      cap_wd_q    <= cap_wd_n;
`endif
    end
  end

  assign set_if.set_ready = (state_q == IDLE) && !pending_q;
  assign set_if.set_done  = done_q;
  assign set_if.set_err   = err_q;
  assign day              = day_q;
  assign month            = month_q;
  assign year             = year_q;
  assign month_wrap       = mw_q;
  assign year_wrap        = yw_q;
`ifdef CAL_WEEKDAY_EN
  assign weekday          = wd_q;
`else
  assign weekday          = 3'd0;
`endif

endmodule

// File: tb/tb_calendar_date.sv
// Scoreboard bench for calendar_date: loads, ticks, leap/century rules, rejects, busy ticks, reset.
module tb_calendar_date;

`ifdef CAL_WEEKDAY_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  typedef struct {
    logic [4:0]  day;
    logic [3:0]  month;
    logic [11:0] year;
    logic [2:0]  wd;
    logic        err;
    logic        mw;
    logic        yw;
  } exp_t;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        day_tick;
  logic [4:0]  day;
  logic [3:0]  month;
  logic [11:0] year;
  logic [2:0]  weekday;
  logic        month_wrap, year_wrap;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  logic [4:0]  cur_day   = 5'd1;
  logic [3:0]  cur_month = 4'd1;
  logic [11:0] cur_year  = 12'd2000;
  logic [2:0]  cur_wd    = 3'd5;

  calendar_date_if #(.YEAR_W(12)) set_if ();

  calendar_date #(.YEAR_W(12), .YEAR_RESET(2000), .WEEKDAY_RESET(5)) dut (
    .clock      (clock),
    .clear_n    (clear_n),
    .day_tick   (day_tick),
    .set_if     (set_if),
    .day        (day),
    .month      (month),
    .year       (year),
    .weekday    (weekday),
    .month_wrap (month_wrap),
    .year_wrap  (year_wrap)
  );

  always #5 clock = ~clock;

  function automatic exp_t cur_exp(input logic err, input logic mw, input logic yw);
    exp_t e;
    e.day = cur_day; e.month = cur_month; e.year = cur_year;
    e.wd = WD_EN ? cur_wd : 3'd0;
    e.err = err; e.mw = mw; e.yw = yw;
    return e;
  endfunction

  task automatic test_reset();
    total++;
    if (day !== 5'd1 || month !== 4'd1 || year !== 12'd2000 || weekday !== (WD_EN ? 3'd5 : 3'd0)) begin
      bad++;
      $display("[TB] FAIL reset_date: got %0d/%0d/%0d wd=%0d, want 1/1/2000 wd=%0d",
               day, month, year, weekday, WD_EN ? 5 : 0);
    end
    total++;
    if ({set_if.set_ready, set_if.set_done, set_if.set_err, month_wrap, year_wrap} !== 5'b10000) begin
      bad++;
      $display("[TB] FAIL reset_flags: got ready/done/err/mw/yw=%b%b%b%b%b, want 10000",
               set_if.set_ready, set_if.set_done, set_if.set_err, month_wrap, year_wrap);
    end
  endtask

  task automatic do_tick(input logic [4:0] d, input logic [3:0] m, input logic [11:0] y,
                         input logic mw, input logic yw);
    exp_t x;
    cur_day = d; cur_month = m; cur_year = y;
    cur_wd = (cur_wd == 3'd6) ? 3'd0 : cur_wd + 3'd1;
    sb.push_back(cur_exp(1'b0, mw, yw));
    @(negedge clock); day_tick = 1'b1;
    @(negedge clock); day_tick = 1'b0;
    x = sb.pop_front();
    total++;
    if (day !== x.day || month !== x.month || year !== x.year || weekday !== x.wd ||
        month_wrap !== x.mw || year_wrap !== x.yw) begin
      bad++;
      $display("[TB] FAIL tick_date: got %0d/%0d/%0d wd=%0d mw=%b yw=%b, want %0d/%0d/%0d wd=%0d mw=%b yw=%b",
               day, month, year, weekday, month_wrap, year_wrap,
               x.day, x.month, x.year, x.wd, x.mw, x.yw);
    end
    @(negedge clock);
    total++;
    if ({month_wrap, year_wrap} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL wrap_pulse_width: got mw=%b yw=%b one cycle later, want 0 0", month_wrap, year_wrap);
    end
  endtask

  task automatic do_load(input logic [4:0] d, input logic [3:0] m, input logic [11:0] y,
                         input logic [2:0] wd, input logic err, input string tag);
    exp_t x;
    int cycles;
    int want_lat;
    if (!err) begin
      cur_day = d; cur_month = m; cur_year = y; cur_wd = wd;
    end
    sb.push_back(cur_exp(err, 1'b0, 1'b0));
    want_lat = int'(y) / 400 + 2;
    @(negedge clock);
    set_if.set_valid = 1'b1;
    set_if.set_day = d; set_if.set_month = m; set_if.set_year = y; set_if.set_weekday = wd;
    cycles = 0;
    while (!set_if.set_ready && cycles < 20) begin @(negedge clock); cycles++; end
    @(negedge clock);
    set_if.set_valid = 1'b0;
    cycles = 1;
    while (!set_if.set_done && cycles < 20) begin @(negedge clock); cycles++; end
    x = sb.pop_front();
    total++;
    if (!set_if.set_done) begin
      bad++;
      $display("[TB] FAIL load_timeout %s: got no set_done in %0d cycles, want done", tag, cycles);
    end else begin
      total++;
      if (cycles !== want_lat) begin
        bad++;
        $display("[TB] FAIL load_latency %s: got %0d cycles, want %0d", tag, cycles, want_lat);
      end
      total++;
      if (set_if.set_err !== x.err) begin
        bad++;
        $display("[TB] FAIL load_err %s: got %b, want %b", tag, set_if.set_err, x.err);
      end
      total++;
      if (day !== x.day || month !== x.month || year !== x.year || weekday !== x.wd) begin
        bad++;
        $display("[TB] FAIL load_date %s: got %0d/%0d/%0d wd=%0d, want %0d/%0d/%0d wd=%0d",
                 tag, day, month, year, weekday, x.day, x.month, x.year, x.wd);
      end
      @(negedge clock);
      total++;
      if (set_if.set_done !== 1'b0) begin
        bad++;
        $display("[TB] FAIL done_pulse_width %s: got done=%b next cycle, want 0", tag, set_if.set_done);
      end
    end
  endtask

  // Ticks arriving while busy (or together with valid) must yield exactly one advance afterwards.
  task automatic test_busy_ticks(input bit with_valid, input logic [4:0] d, input logic [3:0] m,
                                 input logic [11:0] y, input logic [2:0] wd, input string tag);
    exp_t x;
    int cycles;
    cur_day = d; cur_month = m; cur_year = y; cur_wd = wd;
    sb.push_back(cur_exp(1'b0, 1'b0, 1'b0));
    @(negedge clock);
    set_if.set_valid = 1'b1; day_tick = with_valid;
    set_if.set_day = d; set_if.set_month = m; set_if.set_year = y; set_if.set_weekday = wd;
    @(negedge clock);
    set_if.set_valid = 1'b0; day_tick = 1'b0;
    cycles = 1;
    if (!with_valid) begin
      day_tick = 1'b1; @(negedge clock);
      day_tick = 1'b0; @(negedge clock);
      day_tick = 1'b1; @(negedge clock);
      day_tick = 1'b0;
      cycles = 4;
    end
    while (!set_if.set_done && cycles < 20) begin @(negedge clock); cycles++; end
    x = sb.pop_front();
    total++;
    if (!set_if.set_done || day !== x.day || month !== x.month || year !== x.year || weekday !== x.wd) begin
      bad++;
      $display("[TB] FAIL busy_commit %s: got done=%b %0d/%0d/%0d wd=%0d, want done=1 %0d/%0d/%0d wd=%0d",
               tag, set_if.set_done, day, month, year, weekday, x.day, x.month, x.year, x.wd);
    end
    total++;
    if (set_if.set_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL busy_ready_blocked %s: got ready=%b, want 0", tag, set_if.set_ready);
    end
    cur_day = cur_day + 5'd1;
    cur_wd = (cur_wd == 3'd6) ? 3'd0 : cur_wd + 3'd1;
    sb.push_back(cur_exp(1'b0, 1'b0, 1'b0));
    @(negedge clock);
    x = sb.pop_front();
    total++;
    if (day !== x.day || month !== x.month || year !== x.year || weekday !== x.wd) begin
      bad++;
      $display("[TB] FAIL busy_pending_tick %s: got %0d/%0d/%0d wd=%0d, want %0d/%0d/%0d wd=%0d",
               tag, day, month, year, weekday, x.day, x.month, x.year, x.wd);
    end
    total++;
    if (set_if.set_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL busy_ready_back %s: got ready=%b, want 1", tag, set_if.set_ready);
    end
    @(negedge clock);
    total++;
    if (day !== cur_day) begin
      bad++;
      $display("[TB] FAIL busy_single_advance %s: got day %0d, want %0d", tag, day, cur_day);
    end
  endtask

  task automatic test_reset_mid_load();
    bit seen_done;
    @(negedge clock);
    set_if.set_valid = 1'b1;
    set_if.set_day = 5'd1; set_if.set_month = 4'd1; set_if.set_year = 12'd4000; set_if.set_weekday = 3'd0;
    @(negedge clock);
    set_if.set_valid = 1'b0;
    @(negedge clock);
    clear_n = 1'b0;
    cur_day = 5'd1; cur_month = 4'd1; cur_year = 12'd2000; cur_wd = 3'd5;
    #1;
    test_reset();
    @(negedge clock);
    clear_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (set_if.set_done) seen_done = 1'b1;
    end
    total++;
    if (seen_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_no_done: got set_done after reset, want none");
    end
  endtask

  task automatic applyStimulus();
    test_reset();
    do_load(5'd28, 4'd2, 12'd2023, 3'd1, 1'b0, "28/02/2023");
    do_tick(5'd1, 4'd3, 12'd2023, 1'b1, 1'b0);
    do_load(5'd28, 4'd2, 12'd2024, 3'd2, 1'b0, "28/02/2024");
    do_tick(5'd29, 4'd2, 12'd2024, 1'b0, 1'b0);
    do_load(5'd28, 4'd2, 12'd1900, 3'd2, 1'b0, "28/02/1900");
    do_tick(5'd1, 4'd3, 12'd1900, 1'b1, 1'b0);
    do_load(5'd28, 4'd2, 12'd2000, 3'd0, 1'b0, "28/02/2000");
    do_tick(5'd29, 4'd2, 12'd2000, 1'b0, 1'b0);
    do_tick(5'd1, 4'd3, 12'd2000, 1'b1, 1'b0);
    do_load(5'd31, 4'd12, 12'd2099, 3'd3, 1'b0, "31/12/2099");
    do_tick(5'd1, 4'd1, 12'd2100, 1'b1, 1'b1);
    do_load(5'd28, 4'd2, 12'd2100, 3'd6, 1'b0, "28/02/2100");
    do_tick(5'd1, 4'd3, 12'd2100, 1'b1, 1'b0);
    do_load(5'd31, 4'd4, 12'd2024, 3'd1, 1'b1, "31/04/2024");
    do_load(5'd29, 4'd2, 12'd2023, 3'd1, 1'b1, "29/02/2023");
    do_load(5'd0, 4'd5, 12'd2024, 3'd1, 1'b1, "00/05/2024");
    do_load(5'd1, 4'd13, 12'd2024, 3'd1, 1'b1, "01/13/2024");
`ifdef CAL_WEEKDAY_EN
    do_load(5'd1, 4'd5, 12'd2024, 3'd7, 1'b1, "weekday7");
`endif
    do_load(5'd31, 4'd12, 12'd4095, 3'd4, 1'b0, "31/12/4095");
    do_tick(5'd1, 4'd1, 12'd0, 1'b1, 1'b1);
    test_busy_ticks(1'b0, 5'd15, 4'd6, 12'd3000, 3'd2, "calc_ticks");
    test_busy_ticks(1'b1, 5'd10, 4'd10, 12'd2010, 3'd6, "tick_with_valid");
    test_reset_mid_load();
  endtask

  initial begin
    clear_n = 1'b0;
    day_tick = 1'b0;
    set_if.set_valid = 1'b0;
    set_if.set_day = 5'd0; set_if.set_month = 4'd0; set_if.set_year = 12'd0; set_if.set_weekday = 3'd0;
    repeat (3) @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);
    applyStimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
